// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: digit count, active-low segment patterns
// ({g,f,e,d,c,b,a}) for hex 0-F, blank pattern and all-digits-off enable.
package seg7_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [DIGITS-1:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder,
// shared by every display digit.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_display.sv
// Counts counter_16 carry edges in a 3-digit BCD wrap counter and scans
// {din, hundreds, tens, ones} onto a 4-digit common-anode display.
// Optional LEAD_ZERO_BLANK_EN blanks leading zeros of the carry count.
module count_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        din,
    input  logic              cout,
    input  logic              clr,
    input  logic              hold,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic              cout_q;
    logic              rise;
    logic [3:0]        h, t, o;
    logic [15:0]       snap;
    logic [DIV_W-1:0]  div;
    logic              tick;
    logic [1:0]        idx;
    logic [3:0]        nib;
    logic              blank;
    logic [6:0]        enc;
    logic [6:0]        seg_next;

    assign rise = cout & ~cout_q;
    assign tick = (div == DIV_W'(SCAN_DIV - 1));

    // cout_q resets high so a carry already asserted at release is ignored
    always_ff @(posedge clk) begin
        if (!rst) begin
            cout_q <= 1'b1;
            h      <= 4'd0;
            t      <= 4'd0;
            o      <= 4'd0;
        end else begin
            cout_q <= cout;
            if (clr) begin
                h <= 4'd0;
                t <= 4'd0;
                o <= 4'd0;
            end else if (rise) begin
                if (o == 4'd9) begin
                    o <= 4'd0;
                    if (t == 4'd9) begin
                        t <= 4'd0;
                        h <= (h == 4'd9) ? 4'd0 : h + 4'd1;
                    end else begin
                        t <= t + 4'd1;
                    end
                end else begin
                    o <= o + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            snap <= 16'd0;
        end else if (!hold) begin
            snap <= {din, h, t, o};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            div <= '0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_comb begin
        nib   = snap[15:12];
        blank = 1'b0;
        case (idx)
            2'd0: nib = snap[15:12];
            2'd1: nib = snap[3:0];
            2'd2: begin
                nib = snap[7:4];
`ifdef LEAD_ZERO_BLANK_EN
                blank = (snap[11:8] == 4'd0) && (snap[7:4] == 4'd0);
`endif
            end
            default: begin
                nib = snap[11:8];
`ifdef LEAD_ZERO_BLANK_EN
                blank = (snap[11:8] == 4'd0);
`endif
            end
        endcase
    end

    hex_to_seg7 u_dec (
        .hex (nib),
        .seg (enc)
    );

    assign seg_next = blank ? SEG_BLANK : enc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= seg_next;
            dp  <= (idx != 2'd1);
        end
    end

endmodule

// File: tb/tb_count_display.sv
// Directed self-checking bench for count_display with SCAN_DIV=4.
module tb_count_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SOFF = 7'b1111111;
`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b1000000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] din = 4'd0;
    logic       cout = 1'b0;
    logic       clr = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int failures = 0;

    count_display #(.SCAN_DIV(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .cout (cout),
        .clr  (clr),
        .hold (hold),
        .an   (an),
        .seg  (seg),
        .dp   (dp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // returns on the first cycle of a fresh activation of the target digit
    task automatic wait_an(input logic [3:0] target, output bit ok);
        int n;
        n = 0;
        while (an === target && n < 40) begin step(); n++; end
        while (an !== target && n < 80) begin step(); n++; end
        ok = (an === target);
    endtask

    task automatic pulse(input int low);
        cout = 1'b1;
        step();
        cout = 1'b0;
        repeat (low) step();
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b0; cout = 1'b1;
        repeat (3) step();
        checks++;
        if ({an, seg, dp} !== {4'b1111, SOFF, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        rst = 1'b1;
        step();
        checks++;
        if (an !== 4'b1110 || seg !== S0) begin
            failures++;
            $display("FAIL reset_first_digit: got an=%b seg=%b, want an=1110 seg=%b", an, seg, S0);
        end
        step();
        cout = 1'b0;
        wait_an(4'b1101, ok);
        checks++;
        if (!ok || seg !== S0 || dp !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_count: got an=%b seg=%b dp=%b, want an=1101 seg=%b dp=0", an, seg, dp, S0);
        end
    endtask

    task automatic test_hex_digit();
        bit ok;
        din = 4'hA;
        repeat (16) step();
        wait_an(4'b1110, ok);
        checks++;
        if (!ok || seg !== SA || dp !== 1'b1) begin
            failures++;
            $display("FAIL hex_digit0: got an=%b seg=%b dp=%b, want an=1110 seg=%b dp=1", an, seg, dp, SA);
        end
        wait_an(4'b1101, ok);
        checks++;
        if (!ok || seg !== S0 || dp !== 1'b0) begin
            failures++;
            $display("FAIL hex_digit1: got an=%b seg=%b dp=%b, want seg=%b dp=0", an, seg, dp, S0);
        end
        wait_an(4'b1011, ok);
        checks++;
        if (!ok || seg !== LZ || dp !== 1'b1) begin
            failures++;
            $display("FAIL hex_digit2: got an=%b seg=%b dp=%b, want seg=%b dp=1", an, seg, dp, LZ);
        end
        wait_an(4'b0111, ok);
        checks++;
        if (!ok || seg !== LZ) begin
            failures++;
            $display("FAIL hex_digit3: got an=%b seg=%b, want seg=%b", an, seg, LZ);
        end
    endtask

    task automatic test_carry_wrap();
        bit ok;
        repeat (12) pulse(3);
        step(); step();
        wait_an(4'b1101, ok);
        checks++;
        if (!ok || seg !== S2 || dp !== 1'b0) begin
            failures++;
            $display("FAIL count12_ones: got an=%b seg=%b dp=%b, want seg=%b dp=0", an, seg, dp, S2);
        end
        wait_an(4'b1011, ok);
        checks++;
        if (!ok || seg !== S1) begin
            failures++;
            $display("FAIL count12_tens: got an=%b seg=%b, want seg=%b", an, seg, S1);
        end
        wait_an(4'b0111, ok);
        checks++;
        if (!ok || seg !== LZ) begin
            failures++;
            $display("FAIL count12_hund: got an=%b seg=%b, want seg=%b", an, seg, LZ);
        end
        clr = 1'b1; step(); clr = 1'b0;
        repeat (999) pulse(1);
        step(); step();
        for (int d = 1; d < 4; d++) begin
            wait_an(~(4'b0001 << d), ok);
            checks++;
            if (!ok || seg !== S9) begin
                failures++;
                $display("FAIL count999_digit%0d: got an=%b seg=%b, want seg=%b", d, an, seg, S9);
            end
        end
        pulse(1);
        step(); step();
        wait_an(4'b1101, ok);
        checks++;
        if (!ok || seg !== S0) begin
            failures++;
            $display("FAIL wrap_ones: got an=%b seg=%b, want seg=%b", an, seg, S0);
        end
        wait_an(4'b1011, ok);
        checks++;
        if (!ok || seg !== LZ) begin
            failures++;
            $display("FAIL wrap_tens: got an=%b seg=%b, want seg=%b", an, seg, LZ);
        end
        wait_an(4'b0111, ok);
        checks++;
        if (!ok || seg !== LZ) begin
            failures++;
            $display("FAIL wrap_hund: got an=%b seg=%b, want seg=%b", an, seg, LZ);
        end
    endtask

    task automatic test_clear_collision();
        bit ok;
        repeat (3) pulse(1);
        cout = 1'b1; clr = 1'b1;
        step();
        cout = 1'b0; clr = 1'b0;
        step(); step();
        wait_an(4'b1101, ok);
        checks++;
        if (!ok || seg !== S0) begin
            failures++;
            $display("FAIL clr_wins_ones: got an=%b seg=%b, want seg=%b", an, seg, S0);
        end
    endtask

    task automatic test_hold();
        bit ok;
        din = 4'h3;
        repeat (3) step();
        hold = 1'b1;
        din = 4'h7;
        repeat (2) pulse(2);
        wait_an(4'b1110, ok);
        checks++;
        if (!ok || seg !== S3) begin
            failures++;
            $display("FAIL hold_din: got an=%b seg=%b, want seg=%b", an, seg, S3);
        end
        hold = 1'b0;
        step(); step();
        checks++;
        if (an !== 4'b1110 || seg !== S7) begin
            failures++;
            $display("FAIL release_din: got an=%b seg=%b, want an=1110 seg=%b", an, seg, S7);
        end
        wait_an(4'b1101, ok);
        checks++;
        if (!ok || seg !== S2) begin
            failures++;
            $display("FAIL release_count: got an=%b seg=%b, want seg=%b", an, seg, S2);
        end
    endtask

    task automatic test_scan_reset();
        bit ok;
        logic [3:0] exp_an;
        wait_an(4'b1110, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL scan_sync: got an=%b, want 1110", an);
        end
        for (int i = 0; i < 16; i++) begin
            exp_an = ~(4'b0001 << (i / 4));
            checks++;
            if (an !== exp_an) begin
                failures++;
                $display("FAIL scan_order[%0d]: got an=%b, want %b", i, an, exp_an);
            end
            step();
        end
        repeat (5) step();
        rst = 1'b0; cout = 1'b1; clr = 1'b1; hold = 1'b1;
        step();
        checks++;
        if (an !== 4'b1111 || seg !== SOFF || dp !== 1'b1) begin
            failures++;
            $display("FAIL midframe_reset: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        rst = 1'b1; cout = 1'b0; clr = 1'b0; hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_an = (i < 4) ? 4'b1110 : 4'b1101;
            checks++;
            if (an !== exp_an) begin
                failures++;
                $display("FAIL restart_scan[%0d]: got an=%b, want %b", i, an, exp_an);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex_digit();
        test_carry_wrap();
        test_clear_collision();
        test_hold();
        test_scan_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
